// File: rtl/ps2_led_sequencer.sv
// ============================================================================
// ps2_led_sequencer: issues PS/2 Set-LEDs (0xED + LED byte) on lock changes,
// swallows the keyboard's ACK/RESEND replies and forwards all other bytes.
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_led_sequencer #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  input  logic       i_caps,
  input  logic       i_num,
  input  logic       i_scroll,
  input  logic       i_tx_ready,
  input  logic       i_tx_done,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_start,
  output logic [7:0] o_key_byte,
  output logic       o_key_valid,
  output logic       o_busy,
  output logic       o_error
);

  localparam int c_tout_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_retry_w = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [c_tout_w-1:0]  c_tout_last = c_tout_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);
  localparam logic [7:0]           c_set_leds  = 8'hED;
  localparam logic [7:0]           c_ack       = 8'hFA;
  localparam logic [7:0]           c_resend    = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_CMD = 3'd1,
    ST_TX_CMD   = 3'd2,
    ST_ACK_CMD  = 3'd3,
    ST_SEND_LED = 3'd4,
    ST_TX_LED   = 3'd5,
    ST_ACK_LED  = 3'd6
  } state_t;

  state_t                r_state;
  logic [2:0]            r_sent;
  logic [2:0]            r_led;
  logic [c_retry_w-1:0]  r_retry;
  logic [c_tout_w-1:0]   r_tout;
  logic [7:0]            r_tx_byte;
  logic                  r_tx_start;
  logic [7:0]            r_key_byte;
  logic                  r_key_valid;
  logic                  r_error;

  logic [2:0] w_locks;
  logic       w_in_ack;
  logic       w_led_stage;
  logic       w_ack;
  logic       w_nak;
  logic       w_tmo;
  logic       w_progress;
  logic       w_fail;

  assign w_locks     = {i_caps, i_num, i_scroll};
  assign w_in_ack    = (r_state == ST_ACK_CMD) || (r_state == ST_ACK_LED);
  assign w_led_stage = (r_state == ST_SEND_LED) || (r_state == ST_TX_LED) ||
                       (r_state == ST_ACK_LED);
  assign w_ack       = w_in_ack && i_rx_valid && (i_rx_byte == c_ack);
  assign w_nak       = w_in_ack && i_rx_valid && (i_rx_byte == c_resend);
  assign w_tmo       = (r_state != ST_IDLE) && (r_tout == c_tout_last);

  // A reply or handshake arriving on the expiry cycle wins over the timeout.
  assign w_progress  = (((r_state == ST_SEND_CMD) || (r_state == ST_SEND_LED)) && i_tx_ready) ||
                       (((r_state == ST_TX_CMD)   || (r_state == ST_TX_LED))   && i_tx_done)  ||
                       w_ack;
  assign w_fail      = w_nak || (w_tmo && !w_progress);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sent      <= 3'b000;
      r_led       <= 3'b000;
      r_retry     <= '0;
      r_tout      <= '0;
      r_tx_byte   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_key_byte  <= 8'h00;
      r_key_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_key_valid <= 1'b0;

      if (i_rx_valid && !(w_ack || w_nak)) begin
        r_key_byte  <= i_rx_byte;
        r_key_valid <= 1'b1;
      end

      if (r_state != ST_IDLE) begin
        r_tout <= r_tout + 1'b1;
      end

      if (w_fail) begin
        r_tout <= '0;
        if (r_retry < c_max_retry) begin
          r_retry <= r_retry + 1'b1;
          r_state <= w_led_stage ? ST_SEND_LED : ST_SEND_CMD;
        end else begin
          // Latch the LED value as sent so a dead keyboard cannot retrigger forever.
          r_error <= 1'b1;
          r_sent  <= r_led;
          r_state <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_locks != r_sent) begin
              r_led   <= w_locks;
              r_retry <= '0;
              r_tout  <= '0;
              r_state <= ST_SEND_CMD;
            end
          end
          ST_SEND_CMD: begin
            if (i_tx_ready) begin
              r_tx_byte  <= c_set_leds;
              r_tx_start <= 1'b1;
              r_tout     <= '0;
              r_state    <= ST_TX_CMD;
            end
          end
          ST_TX_CMD: begin
            if (i_tx_done) begin
              r_tout  <= '0;
              r_state <= ST_ACK_CMD;
            end
          end
          ST_ACK_CMD: begin
            if (w_ack) begin
              r_tout  <= '0;
              r_state <= ST_SEND_LED;
            end
          end
          ST_SEND_LED: begin
            if (i_tx_ready) begin
              r_tx_byte  <= {5'b00000, r_led};
              r_tx_start <= 1'b1;
              r_tout     <= '0;
              r_state    <= ST_TX_LED;
            end
          end
          ST_TX_LED: begin
            if (i_tx_done) begin
              r_tout  <= '0;
              r_state <= ST_ACK_LED;
            end
          end
          ST_ACK_LED: begin
            if (w_ack) begin
              r_sent  <= r_led;
              r_error <= 1'b0;
              r_tout  <= '0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_tout  <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_tx_byte   = r_tx_byte;
  assign o_tx_start  = r_tx_start;
  assign o_key_byte  = r_key_byte;
  assign o_key_valid = r_key_valid;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ps2_led_sequencer.sv
// ============================================================================
// tb_ps2_led_sequencer: randomized self-checking bench for ps2_led_sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_led_sequencer;

  localparam int TMO  = 100;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       caps = 1'b0, num = 1'b0, scroll = 1'b0;
  logic       tx_ready = 1'b0, tx_done = 1'b0;
  logic [7:0] o_tx_byte, o_key_byte;
  logic       o_tx_start, o_key_valid, o_busy, o_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: last LED value the keyboard has accepted (or aborted on).
  logic [2:0] m_sent = 3'b000;

  logic [7:0] tx_q[$];
  int         txc_q[$];
  logic [7:0] key_q[$];
  int         keyc_q[$];

  ps2_led_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .i_caps(caps), .i_num(num), .i_scroll(scroll),
    .i_tx_ready(tx_ready), .i_tx_done(tx_done),
    .o_tx_byte(o_tx_byte), .o_tx_start(o_tx_start),
    .o_key_byte(o_key_byte), .o_key_valid(o_key_valid),
    .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_tx_start === 1'b1) begin
      tx_q.push_back(o_tx_byte);
      txc_q.push_back(cyc);
    end
    if (o_key_valid === 1'b1) begin
      key_q.push_back(o_key_byte);
      keyc_q.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_locks(input logic [2:0] v);
    @(posedge clk);
    #1 {caps, num, scroll} = v;
  endtask

  task automatic reply(input logic [7:0] b, output int dc);
    @(posedge clk);
    #1 rx_byte = b; rx_valid = 1'b1; dc = cyc;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_done(output int dc);
    repeat (4) @(posedge clk);
    #1 tx_done = 1'b1; dc = cyc;
    @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  task automatic pop_tx(output bit ok, output logic [7:0] b, output int c);
    int n = 0;
    ok = 1'b0; b = 8'h00; c = 0;
    while (tx_q.size() == 0 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    if (tx_q.size() > 0) begin
      ok = 1'b1; b = tx_q.pop_front(); c = txc_q.pop_front();
    end
  endtask

  task automatic pop_key(output bit ok, output logic [7:0] b, output int c);
    int n = 0;
    ok = 1'b0; b = 8'h00; c = 0;
    while (key_q.size() == 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (key_q.size() > 0) begin
      ok = 1'b1; b = key_q.pop_front(); c = keyc_q.pop_front();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_tx_start, o_tx_byte, o_key_valid, o_key_byte} !== 18'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {o_tx_start, o_tx_byte, o_key_valid, o_key_byte});
    end
    checks++;
    if ({o_busy, o_error} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: busy/err got %b want 00", {o_busy, o_error});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(5);
    checks++;
    if (o_busy !== 1'b0 || tx_q.size() != 0) begin
      errors++; $display("FAIL reset_idle: busy %b starts %0d want 0/0", o_busy, tx_q.size());
    end
  endtask

  task automatic test_led_update;
    bit ok; logic [7:0] b; int c, dc;
    tx_ready = 1'b1;
    set_locks(3'b100);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'hED}) begin
      errors++; $display("FAIL upd_cmd: got ok=%b %h want 1 ed", ok, b);
    end
    pulse_done(dc); reply(8'hFA, dc);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'h04}) begin
      errors++; $display("FAIL upd_led: got ok=%b %h want 1 04", ok, b);
    end
    pulse_done(dc); reply(8'hFA, dc);
    wait_cycles(3);
    checks++;
    if ({o_busy, o_error} !== 2'b00 || key_q.size() != 0) begin
      errors++; $display("FAIL upd_end: busy/err %b keys %0d want 00/0", {o_busy, o_error}, key_q.size());
    end
    m_sent = 3'b100;
  endtask

  task automatic test_passthrough;
    logic [7:0] seq[8];
    bit ok; logic [7:0] b; int c, dc;
    seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C;
    for (int i = 3; i < 8; i++) seq[i] = 8'($urandom_range(0, 255));
    seq[7] = 8'hFA;
    for (int i = 0; i < 8; i++) begin
      reply(seq[i], dc);
      pop_key(ok, b, c);
      checks++;
      if ({ok, b} !== {1'b1, seq[i]} || c - dc != 1) begin
        errors++; $display("FAIL pass_%0d: got ok=%b %h lat %0d want 1 %h lat 1", i, ok, b, c - dc, seq[i]);
      end
    end
    wait_cycles(3);
    checks++;
    if (tx_q.size() != 0 || key_q.size() != 0) begin
      errors++; $display("FAIL pass_extra: starts %0d keys %0d want 0/0", tx_q.size(), key_q.size());
    end
  endtask

  task automatic test_resend;
    bit ok; logic [7:0] b; int c, dc;
    set_locks(3'b010);
    for (int k = 0; k < 3; k++) begin
      pop_tx(ok, b, c);
      checks++;
      if ({ok, b} !== {1'b1, 8'hED}) begin
        errors++; $display("FAIL resend_cmd_%0d: got ok=%b %h want 1 ed", k, ok, b);
      end
      pulse_done(dc);
      reply((k < 2) ? 8'hFE : 8'hFA, dc);
    end
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL resend_led: got ok=%b %h want 1 02", ok, b);
    end
    pulse_done(dc); reply(8'hFA, dc);
    wait_cycles(3);
    checks++;
    if ({o_busy, o_error} !== 2'b00 || key_q.size() != 0 || tx_q.size() != 0) begin
      errors++; $display("FAIL resend_end: busy/err %b keys %0d starts %0d want 00/0/0",
                         {o_busy, o_error}, key_q.size(), tx_q.size());
    end
    m_sent = 3'b010;
  endtask

  task automatic test_abort;
    bit ok; logic [7:0] b; int c, dc, n;
    dc = 0;
    set_locks(3'b110);
    for (int i = 0; i <= MAXR; i++) begin
      pop_tx(ok, b, c);
      checks++;
      if ({ok, b} !== {1'b1, 8'hED} || (i > 0 && (c - dc < TMO || c - dc > TMO + 4))) begin
        errors++; $display("FAIL abort_cmd_%0d: got ok=%b %h gap %0d want 1 ed gap ~%0d", i, ok, b, c - dc, TMO);
      end
      pulse_done(dc);
    end
    n = 0;
    while (o_busy !== 1'b0 && n < 200) begin
      wait_cycles(1); n++;
    end
    checks++;
    if ({o_busy, o_error} !== 2'b01) begin
      errors++; $display("FAIL abort_flag: busy/err %b want 01", {o_busy, o_error});
    end
    wait_cycles(300);
    checks++;
    if (tx_q.size() != 0) begin
      errors++; $display("FAIL abort_quiet: extra starts %0d want 0", tx_q.size());
    end
    m_sent = 3'b110;
  endtask

  task automatic test_interleave;
    bit ok; logic [7:0] b; int c, dc;
    set_locks(3'b100);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b, o_error} !== {1'b1, 8'hED, 1'b1}) begin
      errors++; $display("FAIL inter_cmd: got ok=%b %h err %b want 1 ed 1", ok, b, o_error);
    end
    pulse_done(dc); reply(8'hFA, dc);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'h04}) begin
      errors++; $display("FAIL inter_led: got ok=%b %h want 1 04", ok, b);
    end
    pulse_done(dc);
    reply(8'h1C, dc);
    pop_key(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'h1C} || c - dc != 1) begin
      errors++; $display("FAIL inter_fwd: got ok=%b %h lat %0d want 1 1c lat 1", ok, b, c - dc);
    end
    set_locks(3'b101);
    reply(8'hFA, dc);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'hED} || key_q.size() != 0) begin
      errors++; $display("FAIL inter_cmd2: got ok=%b %h keys %0d want 1 ed 0", ok, b, key_q.size());
    end
    pulse_done(dc); reply(8'hFA, dc);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'h05}) begin
      errors++; $display("FAIL inter_led2: got ok=%b %h want 1 05", ok, b);
    end
    pulse_done(dc); reply(8'hFA, dc);
    wait_cycles(3);
    checks++;
    if ({o_busy, o_error} !== 2'b00 || key_q.size() != 0) begin
      errors++; $display("FAIL inter_end: busy/err %b keys %0d want 00/0", {o_busy, o_error}, key_q.size());
    end
    m_sent = 3'b101;
  endtask

  task automatic test_reset_mid;
    bit ok; logic [7:0] b; int c, dc;
    set_locks(3'b100);
    pop_tx(ok, b, c);
    pulse_done(dc); reply(8'hFA, dc);
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'h04}) begin
      errors++; $display("FAIL rmid_led: got ok=%b %h want 1 04", ok, b);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_tx_start, o_tx_byte, o_key_valid, o_key_byte, o_busy, o_error} !== 20'h0) begin
      errors++; $display("FAIL rmid_zero: got %h want 0",
                         {o_tx_start, o_tx_byte, o_key_valid, o_key_byte, o_busy, o_error});
    end
    m_sent = 3'b000;
    pop_tx(ok, b, c);
    checks++;
    if ({ok, b} !== {1'b1, 8'hED}) begin
      errors++; $display("FAIL rmid_restart: got ok=%b %h want 1 ed", ok, b);
    end
    pulse_done(dc); reply(8'hFA, dc);
    pop_tx(ok, b, c);
    pulse_done(dc); reply(8'hFA, dc);
    wait_cycles(3);
    checks++;
    if ({ok, b, o_busy} !== {1'b1, 8'h04, 1'b0}) begin
      errors++; $display("FAIL rmid_done: got ok=%b %h busy %b want 1 04 0", ok, b, o_busy);
    end
    m_sent = 3'b100;
  endtask

  task automatic test_random_seq;
    bit ok; logic [7:0] b, x; int c, dc, ncmd, nled, delay;
    logic [2:0] lock;
    for (int it = 0; it < 6; it++) begin
      tx_ready = 1'b0;
      lock = 3'($urandom_range(0, 7));
      while (lock == m_sent) lock = 3'($urandom_range(0, 7));
      set_locks(lock);
      delay = $urandom_range(2, 10);
      wait_cycles(delay);
      checks++;
      if (tx_q.size() != 0 || o_busy !== 1'b1) begin
        errors++; $display("FAIL rnd_hold_%0d: starts %0d busy %b want 0/1", it, tx_q.size(), o_busy);
      end
      tx_ready = 1'b1;
      ncmd = $urandom_range(0, 2);
      nled = $urandom_range(0, MAXR - ncmd);
      for (int k = 0; k <= ncmd + nled + 1; k++) begin
        pop_tx(ok, b, c);
        checks++;
        if ({ok, b} !== {1'b1, (k <= ncmd) ? 8'hED : {5'b0, lock}}) begin
          errors++; $display("FAIL rnd_tx_%0d_%0d: got ok=%b %h want 1 %h", it, k, ok, b,
                             (k <= ncmd) ? 8'hED : {5'b0, lock});
        end
        pulse_done(dc);
        if ($urandom_range(0, 1) == 1) begin
          x = 8'($urandom_range(0, 255));
          while (x == 8'hFA || x == 8'hFE) x = 8'($urandom_range(0, 255));
          reply(x, dc);
          pop_key(ok, b, c);
          checks++;
          if ({ok, b} !== {1'b1, x} || c - dc != 1) begin
            errors++; $display("FAIL rnd_fwd_%0d_%0d: got ok=%b %h lat %0d want 1 %h lat 1", it, k, ok, b, c - dc, x);
          end
        end
        reply((k == ncmd || k == ncmd + nled + 1) ? 8'hFA : 8'hFE, dc);
      end
      wait_cycles(3);
      checks++;
      if ({o_busy, o_error} !== 2'b00 || key_q.size() != 0 || tx_q.size() != 0) begin
        errors++; $display("FAIL rnd_end_%0d: busy/err %b keys %0d starts %0d want 00/0/0",
                           it, {o_busy, o_error}, key_q.size(), tx_q.size());
      end
      m_sent = lock;
    end
  endtask

  initial begin
    test_reset();
    test_led_update();
    test_passthrough();
    test_resend();
    test_abort();
    test_interleave();
    test_reset_mid();
    test_random_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
